// File: rtl/cpu_program_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes
// an instruction image and a data image into the CPU memories, then enables the CPU.
module cpu_program_loader #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [63:0] o_addr_ext,
    output logic        o_wen_ext,
    output logic        o_ren_ext,
    output logic [31:0] o_wdata_ext,
    output logic [63:0] o_addr_ext_2,
    output logic        o_wen_ext_2,
    output logic        o_ren_ext_2,
    output logic [63:0] o_wdata_ext_2,
    output logic        o_cpu_enable,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [2:0] {
        HDR_I  = 3'd0,
        LOAD_I = 3'd1,
        HDR_D  = 3'd2,
        LOAD_D = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
    localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_WORDS);

    state_t      r_state;
    state_t      w_nextState;

    logic [1:0]  r_byteCnt;
    logic [23:0] r_partial;
    logic [31:0] r_count;
    logic [15:0] r_idx;
    logic        r_highHalf;
    logic [31:0] r_lowHalf;

    logic [63:0] r_addrExt;
    logic        r_wenExt;
    logic [31:0] r_wdataExt;
    logic [63:0] r_addrExt2;
    logic        r_wenExt2;
    logic [63:0] r_wdataExt2;

    logic        w_loading;
    logic        w_accept;
    logic        w_wordDone;
    logic [31:0] w_word;
    logic        w_lastIndex;

    // The 4th byte completes the word combinationally so the write and the
    // state change both land on the edge that accepts it.
    assign w_loading   = (r_state == HDR_I) || (r_state == LOAD_I) ||
                         (r_state == HDR_D) || (r_state == LOAD_D);
    assign w_accept    = i_in_valid && w_loading;
    assign w_wordDone  = w_accept && (r_byteCnt == 2'd3);
    assign w_word      = {i_in_data, r_partial};
    assign w_lastIndex = ({16'd0, r_idx} == (r_count - 32'd1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= HDR_I;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HDR_I: begin
                if (w_wordDone) begin
                    if (w_word > IMEM_LIMIT) begin
                        w_nextState = ERR;
                    end else if (w_word == 32'd0) begin
                        w_nextState = HDR_D;
                    end else begin
                        w_nextState = LOAD_I;
                    end
                end
            end
            LOAD_I: begin
                if (w_wordDone && w_lastIndex) begin
                    w_nextState = HDR_D;
                end
            end
            HDR_D: begin
                if (w_wordDone) begin
                    if (w_word > DMEM_LIMIT) begin
                        w_nextState = ERR;
                    end else if (w_word == 32'd0) begin
                        w_nextState = RUN;
                    end else begin
                        w_nextState = LOAD_D;
                    end
                end
            end
            LOAD_D: begin
                if (w_wordDone && r_highHalf && w_lastIndex) begin
                    w_nextState = RUN;
                end
            end
            RUN:     w_nextState = RUN;
            ERR:     w_nextState = ERR;
            default: w_nextState = HDR_I;
        endcase
    end

    always_comb begin
        o_in_ready   = w_loading;
        o_busy       = w_loading;
        o_cpu_enable = (r_state == RUN);
        o_err        = (r_state == ERR);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byteCnt <= 2'd0;
            r_partial <= 24'd0;
        end else if (w_accept) begin
            r_byteCnt <= r_byteCnt + 2'd1;
            case (r_byteCnt)
                2'd0:    r_partial[7:0]   <= i_in_data;
                2'd1:    r_partial[15:8]  <= i_in_data;
                2'd2:    r_partial[23:16] <= i_in_data;
                default: r_partial        <= r_partial;
            endcase
        end
    end

    // Word-level bookkeeping and the registered memory write ports.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count     <= 32'd0;
            r_idx       <= 16'd0;
            r_highHalf  <= 1'b0;
            r_lowHalf   <= 32'd0;
            r_addrExt   <= 64'd0;
            r_wenExt    <= 1'b0;
            r_wdataExt  <= 32'd0;
            r_addrExt2  <= 64'd0;
            r_wenExt2   <= 1'b0;
            r_wdataExt2 <= 64'd0;
        end else begin
            r_wenExt  <= 1'b0;
            r_wenExt2 <= 1'b0;
            if (w_wordDone) begin
                case (r_state)
                    HDR_I, HDR_D: begin
                        r_count    <= w_word;
                        r_idx      <= 16'd0;
                        r_highHalf <= 1'b0;
                    end
                    LOAD_I: begin
                        r_wenExt   <= 1'b1;
                        r_addrExt  <= {46'd0, r_idx, 2'b00};
                        r_wdataExt <= w_word;
                        r_idx      <= r_idx + 16'd1;
                    end
                    LOAD_D: begin
                        if (!r_highHalf) begin
                            r_lowHalf  <= w_word;
                            r_highHalf <= 1'b1;
                        end else begin
                            r_wenExt2   <= 1'b1;
                            r_addrExt2  <= {45'd0, r_idx, 3'b000};
                            r_wdataExt2 <= {w_word, r_lowHalf};
                            r_highHalf  <= 1'b0;
                            r_idx       <= r_idx + 16'd1;
                        end
                    end
                    default: begin
                        r_count <= r_count;
                    end
                endcase
            end
        end
    end

    assign o_addr_ext    = r_addrExt;
    assign o_wen_ext     = r_wenExt;
    assign o_ren_ext     = 1'b0;
    assign o_wdata_ext   = r_wdataExt;
    assign o_addr_ext_2  = r_addrExt2;
    assign o_wen_ext_2   = r_wenExt2;
    assign o_ren_ext_2   = 1'b0;
    assign o_wdata_ext_2 = r_wdataExt2;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: streams images byte by byte and checks
// the write strobes, enable and error behaviour against hand-computed values.
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [63:0] addrExt;
    logic        wenExt;
    logic        renExt;
    logic [31:0] wdataExt;
    logic [63:0] addrExt2;
    logic        wenExt2;
    logic        renExt2;
    logic [63:0] wdataExt2;
    logic        cpuEnable;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    int          wenCount;
    int          wen2Count;
    int          bothHigh;
    logic [63:0] iAddrLog[$];
    logic [31:0] iDataLog[$];
    logic [63:0] dAddrLog[$];
    logic [63:0] dDataLog[$];
    logic        enAtWen2[$];
    logic [31:0] imem[0:127];
    logic [63:0] dmem[0:127];

    cpu_program_loader #(.IMEM_WORDS(128), .DMEM_WORDS(128)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_in_data(inData),
        .i_in_valid(inValid),
        .o_in_ready(inReady),
        .o_addr_ext(addrExt),
        .o_wen_ext(wenExt),
        .o_ren_ext(renExt),
        .o_wdata_ext(wdataExt),
        .o_addr_ext_2(addrExt2),
        .o_wen_ext_2(wenExt2),
        .o_ren_ext_2(renExt2),
        .o_wdata_ext_2(wdataExt2),
        .o_cpu_enable(cpuEnable),
        .o_busy(busy),
        .o_err(err)
    );

    always #5 clk = ~clk;

    // Behaves as the two SRAMs: captures every write strobe mid-cycle.
    always @(negedge clk) begin
        if (wenExt) begin
            wenCount++;
            iAddrLog.push_back(addrExt);
            iDataLog.push_back(wdataExt);
            if (addrExt < 64'd512) imem[addrExt[8:2]] = wdataExt;
        end
        if (wenExt2) begin
            wen2Count++;
            dAddrLog.push_back(addrExt2);
            dDataLog.push_back(wdataExt2);
            enAtWen2.push_back(cpuEnable);
            if (addrExt2 < 64'd1024) dmem[addrExt2[9:3]] = wdataExt2;
        end
        if (wenExt && wenExt2) bothHigh++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        wenCount = 0;
        wen2Count = 0;
        bothHigh = 0;
        iAddrLog.delete();
        iDataLog.delete();
        dAddrLog.delete();
        dDataLog.delete();
        enAtWen2.delete();
        for (int k = 0; k < 128; k++) begin
            imem[k] = 'x;
            dmem[k] = 'x;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        inValid = 1'b0;
        inData = 8'h00;
        tick(1);
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic sendByte(input logic [7:0] b);
        inValid = 1'b1;
        inData = b;
        tick(1);
        inValid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int maxGap);
        for (int k = 0; k < 4; k++) begin
            if (maxGap > 0) tick($urandom_range(0, maxGap));
            sendByte(w[8*k +: 8]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inValid = 1'b0;
        inData = 8'h00;
        tick(2);
        rst = 1'b0;
        clearLogs();
        checks++; if (wenExt !== 1'b0)     begin errors++; $display("[TB] FAIL reset_wen: got %b want 0", wenExt); end
        checks++; if (wenExt2 !== 1'b0)    begin errors++; $display("[TB] FAIL reset_wen2: got %b want 0", wenExt2); end
        checks++; if (addrExt !== 64'd0)   begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", addrExt); end
        checks++; if (wdataExt !== 32'd0)  begin errors++; $display("[TB] FAIL reset_wdata: got %h want 0", wdataExt); end
        checks++; if (addrExt2 !== 64'd0)  begin errors++; $display("[TB] FAIL reset_addr2: got %h want 0", addrExt2); end
        checks++; if (wdataExt2 !== 64'd0) begin errors++; $display("[TB] FAIL reset_wdata2: got %h want 0", wdataExt2); end
        checks++; if (cpuEnable !== 1'b0)  begin errors++; $display("[TB] FAIL reset_enable: got %b want 0", cpuEnable); end
        checks++; if (err !== 1'b0)        begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
        checks++; if (inReady !== 1'b1)    begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", inReady); end
        checks++; if ({renExt, renExt2} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ren: got %b want 00", {renExt, renExt2}); end
    endtask

    task automatic test_instr_load();
        doReset();
        sendWord(32'd2, 0);
        sendWord(32'h00500093, 0);
        sendByte(8'h13); sendByte(8'h01); sendByte(8'hA0);
        checks++; if (wenExt !== 1'b0) begin errors++; $display("[TB] FAIL instr_wen_early: got %b want 0", wenExt); end
        sendByte(8'h00);
        checks++; if ({wenExt, addrExt, wdataExt} !== {1'b1, 64'd4, 32'h00A00113})
            begin errors++; $display("[TB] FAIL instr_last_pulse: got %b %h %h want 1 4 00a00113", wenExt, addrExt, wdataExt); end
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        checks++; if (cpuEnable !== 1'b0) begin errors++; $display("[TB] FAIL instr_enable_early: got %b want 0", cpuEnable); end
        sendByte(8'h00);
        checks++; if (cpuEnable !== 1'b1) begin errors++; $display("[TB] FAIL instr_enable_rise: got %b want 1", cpuEnable); end
        tick(2);
        checks++; if (wenCount !== 2) begin errors++; $display("[TB] FAIL instr_count: got %0d want 2", wenCount); end
        checks++; if ({iAddrLog[0], iDataLog[0]} !== {64'd0, 32'h00500093})
            begin errors++; $display("[TB] FAIL instr_w0: got %h %h want 0 00500093", iAddrLog[0], iDataLog[0]); end
        checks++; if ({iAddrLog[1], iDataLog[1]} !== {64'd4, 32'h00A00113})
            begin errors++; $display("[TB] FAIL instr_w1: got %h %h want 4 00a00113", iAddrLog[1], iDataLog[1]); end
        checks++; if (wen2Count !== 0) begin errors++; $display("[TB] FAIL instr_no_wen2: got %0d want 0", wen2Count); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL instr_busy_run: got %b want 0", busy); end
    endtask

    task automatic test_post_run();
        int readyCycles;
        int wenBefore;
        readyCycles = 0;
        wenBefore = wenCount + wen2Count;
        inValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            inData = 8'(8'hA0 + k);
            if (inReady) readyCycles++;
            tick(1);
        end
        inValid = 1'b0;
        tick(1);
        checks++; if (readyCycles !== 0) begin errors++; $display("[TB] FAIL run_ready: got %0d ready cycles want 0", readyCycles); end
        checks++; if (wenCount + wen2Count !== wenBefore)
            begin errors++; $display("[TB] FAIL run_strobes: got %0d want %0d", wenCount + wen2Count, wenBefore); end
        checks++; if (cpuEnable !== 1'b1) begin errors++; $display("[TB] FAIL run_enable: got %b want 1", cpuEnable); end
        checks++; if ({addrExt, wdataExt} !== {64'd4, 32'h00A00113})
            begin errors++; $display("[TB] FAIL run_hold: got %h %h want 4 00a00113", addrExt, wdataExt); end
    endtask

    task automatic test_data_load();
        doReset();
        sendWord(32'd0, 0);
        sendWord(32'd2, 0);
        sendWord(32'h55667788, 0);
        sendWord(32'h11223344, 0);
        sendWord(32'h00000001, 0);
        sendWord(32'hFFFFFFFF, 0);
        checks++; if ({wenExt2, cpuEnable} !== 2'b11)
            begin errors++; $display("[TB] FAIL data_last_cycle: got wen2=%b en=%b want 1 1", wenExt2, cpuEnable); end
        checks++; if ({addrExt2, wdataExt2} !== {64'd8, 64'hFFFFFFFF00000001})
            begin errors++; $display("[TB] FAIL data_last_pulse: got %h %h want 8 ffffffff00000001", addrExt2, wdataExt2); end
        tick(2);
        checks++; if (wen2Count !== 2) begin errors++; $display("[TB] FAIL data_count: got %0d want 2", wen2Count); end
        checks++; if ({dAddrLog[0], dDataLog[0]} !== {64'd0, 64'h1122334455667788})
            begin errors++; $display("[TB] FAIL data_w0: got %h %h want 0 1122334455667788", dAddrLog[0], dDataLog[0]); end
        checks++; if ({enAtWen2[0], enAtWen2[1]} !== 2'b01)
            begin errors++; $display("[TB] FAIL data_enable_align: got %b%b want 01", enAtWen2[0], enAtWen2[1]); end
        checks++; if (wenCount !== 0 || bothHigh !== 0)
            begin errors++; $display("[TB] FAIL data_no_wen: got wen=%0d both=%0d want 0 0", wenCount, bothHigh); end
    endtask

    task automatic test_overflow();
        logic [31:0] niVals[3];
        logic [31:0] ndVals[3];
        niVals = '{32'd129, 32'd0, 32'h00010000};
        ndVals = '{32'd0, 32'd129, 32'd0};
        for (int c = 0; c < 3; c++) begin
            doReset();
            sendWord(niVals[c], 0);
            if (niVals[c] == 32'd0) sendWord(ndVals[c], 0);
            checks++; if ({err, inReady, cpuEnable, busy} !== 4'b1000)
                begin errors++; $display("[TB] FAIL overflow_state_%0d: got err=%b rdy=%b en=%b busy=%b want 1 0 0 0", c, err, inReady, cpuEnable, busy); end
            sendWord(32'h00000001, 0);
            sendWord(32'h00000013, 0);
            tick(2);
            checks++; if ({wenCount, wen2Count} !== {32'd0, 32'd0} || cpuEnable !== 1'b0 || err !== 1'b1)
                begin errors++; $display("[TB] FAIL overflow_quiet_%0d: got wen=%0d wen2=%0d en=%b err=%b want 0 0 0 1", c, wenCount, wen2Count, cpuEnable, err); end
        end
        doReset();
        sendWord(32'd128, 0);
        checks++; if ({err, inReady} !== 2'b01)
            begin errors++; $display("[TB] FAIL ni_max_ok: got err=%b rdy=%b want 0 1", err, inReady); end
    endtask

    task automatic test_gaps();
        logic [31:0] instr[4];
        logic [63:0] data[3];
        int bad;
        instr = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000073};
        data  = '{64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D, 64'h8000000000000001};
        doReset();
        sendWord(32'd4, 5);
        for (int k = 0; k < 4; k++) sendWord(instr[k], 5);
        sendWord(32'd3, 5);
        for (int k = 0; k < 3; k++) begin
            sendWord(data[k][31:0], 5);
            sendWord(data[k][63:32], 5);
        end
        for (int t = 0; t < 10 && cpuEnable !== 1'b1; t++) tick(1);
        tick(1);
        checks++; if (cpuEnable !== 1'b1) begin errors++; $display("[TB] FAIL gaps_enable: got %b want 1 (timeout)", cpuEnable); end
        bad = 0;
        for (int k = 0; k < 4; k++) if (imem[k] !== instr[k]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL gaps_imem: got %0d wrong words want 0 (w0=%h)", bad, imem[0]); end
        bad = 0;
        for (int k = 0; k < 3; k++) if (dmem[k] !== data[k]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL gaps_dmem: got %0d wrong words want 0 (d0=%h)", bad, dmem[0]); end
        checks++; if ({wenCount, wen2Count, bothHigh} !== {32'd4, 32'd3, 32'd0})
            begin errors++; $display("[TB] FAIL gaps_counts: got %0d %0d %0d want 4 3 0", wenCount, wen2Count, bothHigh); end
    endtask

    task automatic test_reset_midload();
        doReset();
        sendWord(32'd4, 0);
        sendWord(32'h11111111, 0);
        sendWord(32'h22222222, 0);
        sendByte(8'h33); sendByte(8'h33);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clearLogs();
        checks++; if ({wenExt, addrExt, wdataExt, cpuEnable, err} !== {1'b0, 64'd0, 32'd0, 1'b0, 1'b0})
            begin errors++; $display("[TB] FAIL midreset_outputs: got wen=%b addr=%h data=%h en=%b err=%b want all 0", wenExt, addrExt, wdataExt, cpuEnable, err); end
        checks++; if ({busy, inReady} !== 2'b11)
            begin errors++; $display("[TB] FAIL midreset_busy: got busy=%b rdy=%b want 1 1", busy, inReady); end
        sendWord(32'd1, 0);
        sendWord(32'hCAFEBABE, 0);
        sendWord(32'd0, 0);
        tick(1);
        checks++; if ({wenCount, iAddrLog[0], iDataLog[0]} !== {32'd1, 64'd0, 32'hCAFEBABE})
            begin errors++; $display("[TB] FAIL midreset_reload: got n=%0d %h %h want 1 0 cafebabe", wenCount, iAddrLog[0], iDataLog[0]); end
        checks++; if (cpuEnable !== 1'b1) begin errors++; $display("[TB] FAIL midreset_enable: got %b want 1", cpuEnable); end
    endtask

    initial begin
        test_reset();
        test_instr_load();
        test_post_run();
        test_data_load();
        test_overflow();
        test_gaps();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
